// File: rtl/ps2_defs.sv
// Shared PS/2 definitions for the host transmitter and the receiver.
// Contents: host-transmit state encoding and the default cycle counts
// for clock-line inhibit and the device clock-edge timeout.
package ps2_defs;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INHIBIT   = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } ps2_host_state_t;

    // 120 us of clock inhibit at 50 MHz
    localparam int unsigned PS2_INHIBIT_CYCLES = 6000;
    // 20 ms between device clock falling edges at 50 MHz
    localparam int unsigned PS2_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 pin, with a falling-edge pulse.
// Ports:
//   clock   - system clock
//   resetn  - asynchronous active-low reset
//   i_pin   - raw pin level
//   o_sync  - synchronized pin level
//   o_fall  - high for one cycle when o_sync went 1 -> 0
// All flops reset to 1 (idle bus) so releasing reset never looks like an edge.
module ps2_sync_edge (
    input  logic clock,
    input  logic resetn,
    input  logic i_pin,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock line, issues the
// start bit, then shifts 8 data bits (LSB first), odd parity and stop on
// device clock falling edges, and checks the device acknowledge.
// Ports:
//   clock, resetn           - system clock, asynchronous active-low reset
//   tx_data, tx_valid       - byte to send and request strobe
//   tx_ready                - idle, a request will be accepted
//   ps2_clk_in/ps2_data_in  - raw pin levels
//   ps2_clk_oe/ps2_data_oe  - 1 = pull the line low, 0 = release
//   busy                    - any state other than idle
//   tx_done / tx_error      - one-cycle result pulses
module ps2_host_tx
    import ps2_defs::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_host_state_t  r_state;
    logic [8:0]       r_frame;      // {parity, data[7:0]}
    logic [3:0]       r_edge_cnt;   // falling edges seen in SEND
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_idle_cnt;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_done;
    logic             r_error;

    logic w_clk_sync;
    logic w_clk_fall;
    logic w_data_sync;
    logic w_data_fall;
    logic w_bus_idle;

    ps2_sync_edge u_sync_clk (
        .clock  (clock),
        .resetn (resetn),
        .i_pin  (ps2_clk_in),
        .o_sync (w_clk_sync),
        .o_fall (w_clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clock  (clock),
        .resetn (resetn),
        .i_pin  (ps2_data_in),
        .o_sync (w_data_sync),
        .o_fall (w_data_fall)
    );

    // Both lines high; any edge restarts the idle qualification.
    assign w_bus_idle = w_clk_sync & w_data_sync & ~w_clk_fall & ~w_data_fall;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_frame    <= '0;
            r_edge_cnt <= '0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_idle_cnt <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (tx_valid) begin
                        r_frame    <= {~^tx_data, tx_data};
                        r_edge_cnt <= '0;
                        r_inh_cnt  <= '0;
                        r_to_cnt   <= '0;
                        r_idle_cnt <= 1'b0;
                        r_clk_oe   <= 1'b1;
                        r_state    <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b1;   // start bit
                        r_edge_cnt <= '0;
                        r_to_cnt   <= '0;
                        r_state    <= ST_SEND;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_clk_fall) begin
                        r_to_cnt   <= '0;
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                        // Edge n (1..9) drives frame bit n-1, i.e. the count before increment.
                        if (r_edge_cnt <= 4'd8) begin
                            r_data_oe <= ~r_frame[r_edge_cnt];
                        end else if (r_edge_cnt == 4'd9) begin
                            r_data_oe <= 1'b0;   // stop bit
                        end else begin
                            r_done     <= ~w_data_sync;
                            r_error    <= w_data_sync;
                            r_clk_oe   <= 1'b0;
                            r_data_oe  <= 1'b0;
                            r_idle_cnt <= 1'b0;
                            r_state    <= ST_WAIT_IDLE;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_error    <= 1'b1;
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        r_idle_cnt <= 1'b0;
                        r_state    <= ST_WAIT_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (w_bus_idle) begin
                        if (r_idle_cnt) begin
                            r_idle_cnt <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_idle_cnt <= 1'b1;
                        end
                    end else begin
                        r_idle_cnt <= 1'b0;
                    end
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_done     = r_done;
    assign tx_error    = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a device model.
// Expected frame bits and outcomes are queued when a byte is offered and
// compared as the device model samples the bus / the result pulse appears.
module tb_ps2_host_tx;

    logic       clock;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    logic dev_clk_low;
    logic dev_data_low;
    logic line_clk;
    logic line_data;

    assign line_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign line_data = ~(ps2_data_oe | dev_data_low);

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;

    logic exp_bits[$];
    int   exp_out[$];   // 0 = done, 1 = error, 2 = no pulse (reset)

    ps2_host_tx #(
        .INHIBIT_CYCLES (20),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (line_clk),
        .ps2_data_in (line_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (tx_done)             n_done++;
        if (tx_error)            n_err++;
        if (tx_done && tx_error) n_both++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input int n_edges, input bit ack,
                             input bit inject, input int rst_edge);
        int         cnt;
        int         ones;
        int         d0;
        int         e0;
        int         outc;
        logic [10:0] frm;
        logic       seen;

        ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        frm = {1'b1, (ones % 2 == 0), b, 1'b0};
        for (int i = 0; i < 11; i++) exp_bits.push_back(frm[i]);
        exp_out.push_back(rst_edge > 0 ? 2 : (n_edges < 11 ? 1 : (ack ? 0 : 1)));
        d0   = n_done;
        e0   = n_err;
        outc = 2;

        chk("ready_before", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        chk("busy_accept", busy, 1);
        chk("ready_accept", tx_ready, 0);

        cnt  = 0;
        seen = 1'b0;
        while (ps2_clk_oe && cnt < 100) begin
            if (ps2_data_oe) seen = 1'b1;
            tx_valid = inject && (cnt == 5);
            if (tx_valid) tx_data = 8'h55;
            tick(1);
            cnt++;
        end
        tx_valid = 1'b0;
        chk("inhibit_len", cnt, 20);
        chk("inhibit_data_oe", seen, 0);
        chk("start_bit_oe", ps2_data_oe, 1);

        for (int k = 0; k < n_edges; k++) begin
            tick(5);
            if (exp_bits.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL sb_empty: observed=empty expected=frame bit");
            end else begin
                chk($sformatf("bit%0d", k), line_data, exp_bits.pop_front());
            end
            if (k == 10) dev_data_low = ack;
            tick(2);
            dev_clk_low = 1'b1;
            if (k + 1 == rst_edge) begin
                tick(2);
                resetn = 1'b0;
                #1;
                chk("rst_clk_oe", ps2_clk_oe, 0);
                chk("rst_data_oe", ps2_data_oe, 0);
                chk("rst_ready", tx_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_pulses", {tx_done, tx_error}, 0);
                tick(3);
                dev_clk_low = 1'b0;
                tick(2);
                resetn = 1'b1;
                tick(5);
                outc = exp_out.pop_front();
                chk("rst_no_done", n_done - d0, (outc == 0) ? 1 : 0);
                chk("rst_no_err", n_err - e0, (outc == 1) ? 1 : 0);
                exp_bits.delete();
                return;
            end
            if (k == n_edges - 1) begin
                cnt = 0;
                while (!tx_done && !tx_error && cnt < 1000) begin
                    tick(1);
                    cnt++;
                    if (cnt == 10) dev_clk_low = 1'b0;
                end
                // 2 sync flops + 1 edge-compare cycle, plus the timeout count
                chk("end_latency", cnt, (n_edges < 11) ? 3 + 200 : 3);
                outc = exp_out.pop_front();
                chk("done_pulse", tx_done, (outc == 0) ? 1 : 0);
                chk("err_pulse", tx_error, (outc == 1) ? 1 : 0);
                tick(1);
                chk("pulse_width", tx_done | tx_error, 0);
                chk("end_clk_oe", ps2_clk_oe, 0);
                chk("end_data_oe", ps2_data_oe, 0);
                if (cnt + 1 < 10) tick(9 - cnt);
                dev_clk_low = 1'b0;
                if (ack && n_edges == 11) begin
                    tick(6);
                    chk("hold_wait_idle", tx_ready, 0);
                    dev_data_low = 1'b0;
                end
                cnt = 0;
                while (!tx_ready && cnt < 50) begin
                    tick(1);
                    cnt++;
                end
                chk("back_idle", tx_ready, 1);
            end else begin
                tick(10);
                dev_clk_low = 1'b0;
            end
        end
        exp_bits.delete();
        tick(3);
        chk("done_count", n_done - d0, (outc == 0) ? 1 : 0);
        chk("err_count", n_err - e0, (outc == 1) ? 1 : 0);

        if (inject) begin
            seen = 1'b0;
            repeat (30) begin
                tick(1);
                if (ps2_clk_oe || busy) seen = 1'b1;
            end
            chk("no_queued_frame", seen, 0);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        tick(3);
        chk("reset_ready", tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_clk_oe", ps2_clk_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_pulses", {tx_done, tx_error}, 0);
        resetn = 1'b1;
        tick(3);
        chk("post_reset_idle", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);

        run_frame(8'hED, 11, 1'b1, 1'b0, 0);   // normal frame, acknowledged
        run_frame(8'h00, 11, 1'b1, 1'b0, 0);   // all-zero data, parity 1
        run_frame(8'hA3, 11, 1'b0, 1'b0, 0);   // no acknowledge
        run_frame(8'h3C, 4,  1'b0, 1'b0, 0);   // device stops after edge 4
        run_frame(8'h81, 11, 1'b1, 1'b1, 0);   // 0x55 offered mid-frame
        run_frame(8'h5A, 11, 1'b1, 1'b0, 6);   // reset during edge 6
        run_frame(8'hF4, 11, 1'b1, 1'b0, 0);   // normal frame after reset

        tick(2);
        chk("never_both_pulses", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
